// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start/data/parity/stop detection with
// 3-sample majority voting, LSB-first shift-in and one-cycle result pulses.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]   BIT_ONE  = BIT_W'(1);
  localparam logic [PRESC_W-1:0] CNT_ZERO = PRESC_W'(0);
  localparam logic [PRESC_W-1:0] CNT_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] CNT_TWO  = PRESC_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic vote3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Parity bit value the transmitter should have sent: even -> ^data, odd -> ~^data.
  function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                  state_q, state_d;
  logic [PRESC_W-1:0]      edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]              samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_typ_q, par_typ_d;
  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic                    par_mis_q, par_mis_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;

  logic [PRESC_W-1:0]      half_s;
  logic [PRESC_W-1:0]      last_s;
  logic                    bit_end_s;
  logic                    voted_s;
  logic                    start_det_s;

  assign half_s      = {1'b0, presc_q[PRESC_W-1:1]};
  assign last_s      = presc_q - CNT_ONE;
  assign bit_end_s   = (state_q != ST_IDLE) && (edge_cnt_q == last_s);
  assign voted_s     = vote3(samp_q);
  assign start_det_s = (state_q == ST_IDLE) && !RX_IN;

  assign P_DATA     = p_data_q;
  assign Data_Valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

  // Edge counter and the three mid-bit samples feeding the vote.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    samp_d     = samp_q;
    if (state_q == ST_IDLE) begin
      edge_cnt_d = start_det_s ? CNT_ONE : CNT_ZERO;
    end else if (bit_end_s) begin
      edge_cnt_d = CNT_ZERO;
    end else begin
      edge_cnt_d = edge_cnt_q + CNT_ONE;
    end
    if (state_q == ST_IDLE) begin
      samp_d = samp_q;
    end else if (edge_cnt_q == (half_s - CNT_TWO)) begin
      samp_d[0] = RX_IN;
    end else if (edge_cnt_q == (half_s - CNT_ONE)) begin
      samp_d[1] = RX_IN;
    end else if (edge_cnt_q == half_s) begin
      samp_d[2] = RX_IN;
    end else begin
      samp_d = samp_q;
    end
  end

  // Frame FSM: bit-end decisions, config latch and result pulses.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    presc_d      = presc_q;
    par_mis_d    = par_mis_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_det_s) begin
          state_d   = ST_START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          presc_d   = Prescale;
          par_mis_d = 1'b0;
          bit_cnt_d = {BIT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = voted_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_d = {voted_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = {BIT_W{1'b0}};
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          par_mis_d = (voted_s != exp_parity(shift_q, par_typ_q));
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_d   = ST_IDLE;
          stp_err_d = ~voted_s;
          par_err_d = par_mis_q;
          if (voted_s && !par_mis_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end else begin
            p_data_d = p_data_q;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      edge_cnt_q   <= CNT_ZERO;
      bit_cnt_q    <= {BIT_W{1'b0}};
      samp_q       <= 3'b000;
      shift_q      <= {DATA_WIDTH{1'b0}};
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      presc_q      <= CNT_ZERO;
      par_mis_q    <= 1'b0;
      p_data_q     <= {DATA_WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      presc_q      <= presc_d;
      par_mis_q    <= par_mis_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

endmodule
